// File: rtl/kf8288_seq_pkg.sv
// Shared types and helpers for the KF8288 bus sequencer.
// The optional Tw timeout is enabled with the KF8288_SEQ_TIMEOUT_EN macro (see top).
package kf8288_seq_pkg;

  typedef enum logic [2:0] {
    ST_INTA    = 3'b000,
    ST_IOR     = 3'b001,
    ST_IOW     = 3'b010,
    ST_HALT    = 3'b011,
    ST_FETCH   = 3'b100,
    ST_MEMR    = 3'b101,
    ST_MEMW    = 3'b110,
    ST_PASSIVE = 3'b111
  } bus_status_t;

  typedef enum logic [2:0] {
    SEQ_IDLE     = 3'd0,
    SEQ_HANDOVER = 3'd1,
    SEQ_T1       = 3'd2,
    SEQ_T2       = 3'd3,
    SEQ_T3       = 3'd4,
    SEQ_TW       = 3'd5,
    SEQ_T4       = 3'd6
  } seq_state_t;

  localparam logic [2:0] STATUS_PASSIVE = 3'b111;

  // 011 would be HALT on a real 8086; requesters may not ask for it (nor 111)
  function automatic logic is_illegal_type(input logic [2:0] t);
    return (t[1:0] == 2'b11);
  endfunction

  function automatic logic is_write_type(input logic [2:0] t);
    return (t == ST_IOW) || (t == ST_MEMW);
  endfunction

endpackage

// File: rtl/kf8288_bus_sequencer_if.sv
// Requester and KF8288-side signals of the bus sequencer, grouped as one interface.
interface kf8288_bus_sequencer_if #(parameter int ADDR_WIDTH = 20);
  logic                  m0_req;
  logic                  m1_req;
  logic [2:0]            m0_type;
  logic [2:0]            m1_type;
  logic [ADDR_WIDTH-1:0] m0_addr;
  logic [ADDR_WIDTH-1:0] m1_addr;
  logic [7:0]            m0_wdata;
  logic [7:0]            m1_wdata;
  logic                  m0_ack;
  logic                  m1_ack;
  logic                  ack_err;
  logic [7:0]            rdata;
  logic                  bus_ready;
  logic [7:0]            bus_rdata;
  logic [2:0]            processor_status;
  logic                  address_enable_n;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [7:0]            bus_wdata;
  logic                  bus_wdata_oe;
  logic                  owner;

  modport slave (
    input  m0_req, m1_req, m0_type, m1_type, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  bus_ready, bus_rdata,
    output m0_ack, m1_ack, ack_err, rdata, processor_status, address_enable_n,
    output bus_addr, bus_wdata, bus_wdata_oe, owner
  );

  modport master (
    output m0_req, m1_req, m0_type, m1_type, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output bus_ready, bus_rdata,
    input  m0_ack, m1_ack, ack_err, rdata, processor_status, address_enable_n,
    input  bus_addr, bus_wdata, bus_wdata_oe, owner
  );
endinterface

// File: rtl/kf8288_seq_arbiter.sv
// Fixed-priority (m1 over m0) requester select with the bus owner register.
module kf8288_seq_arbiter (
  input  logic clock,
  input  logic reset_in,
  input  logic m0_req_i,
  input  logic m1_req_i,
  input  logic owner_load_i,
  output logic any_req_o,
  output logic grant_o,
  output logic handover_o,
  output logic owner_o
);
  logic owner_q;
  logic owner_d;

  assign any_req_o  = m0_req_i | m1_req_i;
  assign grant_o    = m1_req_i;
  assign handover_o = any_req_o & (grant_o != owner_q);
  assign owner_o    = owner_q;

  // Owner follows the grant only when the sequencer commits to a handover
  always_comb begin
    if (owner_load_i) begin
      owner_d = grant_o;
    end else begin
      owner_d = owner_q;
    end
  end

  // Owner register
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      owner_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
    end
  end
endmodule

// File: rtl/kf8288_bus_sequencer.sv
// Sequences 8086 T-states for two requesters in front of a KF8288 bus controller.
// Optional: define KF8288_SEQ_TIMEOUT_EN to force completion after TIMEOUT_CYCLES Tw cycles.
module kf8288_bus_sequencer
  import kf8288_seq_pkg::*;
#(
  parameter int WAIT_STATES    = 0,
  parameter int ADDR_WIDTH     = 20,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clock,
  input logic reset_in,
  kf8288_bus_sequencer_if.slave sif
);
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

  seq_state_t            state_q, state_d;
  logic [2:0]            type_q, type_d, status_q, status_d;
  logic                  aen_n_q, aen_n_d, oe_q, oe_d, err_q, err_d;
  logic                  m0_ack_q, m0_ack_d, m1_ack_q, m1_ack_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  any_req_s, grant_s, handover_s, owner_s, owner_load_s;
  logic [2:0]            win_type_s;
  logic [ADDR_WIDTH-1:0] win_addr_s;
  logic [7:0]            win_wdata_s;
`ifdef KF8288_SEQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0]       tcnt_q, tcnt_d;
`endif

  kf8288_seq_arbiter u_arb (
    .clock        (clock),
    .reset_in     (reset_in),
    .m0_req_i     (sif.m0_req),
    .m1_req_i     (sif.m1_req),
    .owner_load_i (owner_load_s),
    .any_req_o    (any_req_s),
    .grant_o      (grant_s),
    .handover_o   (handover_s),
    .owner_o      (owner_s)
  );

  // Request fields of the arbitration winner
  always_comb begin
    if (grant_s) begin
      win_type_s  = sif.m1_type;
      win_addr_s  = sif.m1_addr;
      win_wdata_s = sif.m1_wdata;
    end else begin
      win_type_s  = sif.m0_type;
      win_addr_s  = sif.m0_addr;
      win_wdata_s = sif.m0_wdata;
    end
  end

  // T-state sequencing; every output is computed for the state being entered
  always_comb begin
    state_d      = state_q;
    type_d       = type_q;
    status_d     = status_q;
    aen_n_d      = aen_n_q;
    oe_d         = oe_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    wcnt_d       = wcnt_q;
    err_d        = 1'b0;
    m0_ack_d     = 1'b0;
    m1_ack_d     = 1'b0;
    owner_load_s = 1'b0;
`ifdef KF8288_SEQ_TIMEOUT_EN
    tcnt_d       = tcnt_q;
`endif
    case (state_q)
      SEQ_IDLE: begin
        status_d = STATUS_PASSIVE;
        aen_n_d  = 1'b1;
        if (any_req_s && is_illegal_type(win_type_s)) begin
          // Rejected without touching the bus or the owner
          m0_ack_d = ~grant_s;
          m1_ack_d = grant_s;
          err_d    = 1'b1;
        end else if (any_req_s) begin
          type_d  = win_type_s;
          addr_d  = win_addr_s;
          wdata_d = win_wdata_s;
          if (handover_s) begin
            owner_load_s = 1'b1;
            state_d      = SEQ_HANDOVER;
          end else begin
            state_d  = SEQ_T1;
            status_d = win_type_s;
            aen_n_d  = 1'b0;
          end
        end else begin
          state_d = SEQ_IDLE;
        end
      end
      SEQ_HANDOVER: begin
        state_d  = SEQ_T1;
        status_d = type_q;
        aen_n_d  = 1'b0;
      end
      SEQ_T1: begin
        state_d = SEQ_T2;
        oe_d    = is_write_type(type_q);
      end
      SEQ_T2: begin
        state_d = SEQ_T3;
        wcnt_d  = 4'd0;
`ifdef KF8288_SEQ_TIMEOUT_EN
        tcnt_d  = '0;
`endif
      end
      SEQ_T3, SEQ_TW: begin
        if (sif.bus_ready && (wcnt_q == WAIT_CNT)) begin
          state_d  = SEQ_T4;
          status_d = STATUS_PASSIVE;
          rdata_d  = sif.bus_rdata;
          m0_ack_d = ~owner_s;
          m1_ack_d = owner_s;
`ifdef KF8288_SEQ_TIMEOUT_EN
        end else if ((state_q == SEQ_TW) && !sif.bus_ready && (tcnt_q == TO_LAST)) begin
          state_d  = SEQ_T4;
          status_d = STATUS_PASSIVE;
          rdata_d  = 8'hFF;
          err_d    = 1'b1;
          m0_ack_d = ~owner_s;
          m1_ack_d = owner_s;
`endif
        end else begin
          state_d = SEQ_TW;
          if (wcnt_q != WAIT_CNT) begin
            wcnt_d = wcnt_q + 4'd1;
          end else begin
            wcnt_d = wcnt_q;
          end
`ifdef KF8288_SEQ_TIMEOUT_EN
          // Only consecutive not-ready Tw cycles count toward the timeout
          if ((state_q == SEQ_TW) && !sif.bus_ready) begin
            tcnt_d = tcnt_q + TO_W'(1);
          end else begin
            tcnt_d = '0;
          end
`endif
        end
      end
      SEQ_T4: begin
        oe_d = 1'b0;
        // Same-owner follow-on request chains straight into T1 with AEN_n held low
        if (any_req_s && !handover_s && !is_illegal_type(win_type_s)) begin
          state_d  = SEQ_T1;
          type_d   = win_type_s;
          addr_d   = win_addr_s;
          wdata_d  = win_wdata_s;
          status_d = win_type_s;
          aen_n_d  = 1'b0;
        end else begin
          state_d  = SEQ_IDLE;
          status_d = STATUS_PASSIVE;
          aen_n_d  = 1'b1;
        end
      end
      default: begin
        state_d  = SEQ_IDLE;
        status_d = STATUS_PASSIVE;
        aen_n_d  = 1'b1;
        oe_d     = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= SEQ_IDLE;
      type_q   <= STATUS_PASSIVE;
      status_q <= STATUS_PASSIVE;
      aen_n_q  <= 1'b1;
      oe_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      rdata_q  <= 8'h00;
      wcnt_q   <= 4'd0;
      err_q    <= 1'b0;
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
`ifdef KF8288_SEQ_TIMEOUT_EN
      tcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      type_q   <= type_d;
      status_q <= status_d;
      aen_n_q  <= aen_n_d;
      oe_q     <= oe_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      m0_ack_q <= m0_ack_d;
      m1_ack_q <= m1_ack_d;
`ifdef KF8288_SEQ_TIMEOUT_EN
      tcnt_q   <= tcnt_d;
`endif
    end
  end

  assign sif.processor_status = status_q;
  assign sif.address_enable_n = aen_n_q;
  assign sif.bus_addr         = addr_q;
  assign sif.bus_wdata        = wdata_q;
  assign sif.bus_wdata_oe     = oe_q;
  assign sif.rdata            = rdata_q;
  assign sif.ack_err          = err_q;
  assign sif.m0_ack           = m0_ack_q;
  assign sif.m1_ack           = m1_ack_q;
  assign sif.owner            = owner_s;
endmodule

// File: tb/tb_kf8288_bus_sequencer.sv
// Scoreboard bench for kf8288_bus_sequencer: directed requests, acks checked by a monitor.
module tb_kf8288_bus_sequencer;
  logic clock = 1'b0;
  logic reset_in;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  kf8288_bus_sequencer_if #(.ADDR_WIDTH(20)) sif ();

  kf8288_bus_sequencer #(
    .WAIT_STATES    (0),
    .ADDR_WIDTH     (20),
`ifdef KF8288_SEQ_TIMEOUT_EN
    .TIMEOUT_CYCLES (4)
`else
    .TIMEOUT_CYCLES (255)
`endif
  ) dut (
    .clock    (clock),
    .reset_in (reset_in),
    .sif      (sif)
  );

  typedef struct {
    logic       who;
    logic       err;
    logic       chk_rd;
    logic [7:0] rd;
    int         at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  logic [2:0]  st_tr   [0:1023];
  logic        aen_tr  [0:1023];
  logic        oe_tr   [0:1023];
  logic        own_tr  [0:1023];
  logic [19:0] addr_tr [0:1023];
  logic [7:0]  wd_tr   [0:1023];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_ack(input logic who, input logic err, input logic chk_rd,
                            input logic [7:0] rd, input int at);
    exp_t e;
    e.who = who; e.err = err; e.chk_rd = chk_rd; e.rd = rd; e.at = at;
    sbq.push_back(e);
  endtask

  // Trace recorder and ack monitor
  always @(negedge clock) begin
    if (cyc < 1024) begin
      st_tr[cyc]   = sif.processor_status;
      aen_tr[cyc]  = sif.address_enable_n;
      oe_tr[cyc]   = sif.bus_wdata_oe;
      own_tr[cyc]  = sif.owner;
      addr_tr[cyc] = sif.bus_addr;
      wd_tr[cyc]   = sif.bus_wdata;
    end
    if (!reset_in && (sif.m0_ack || sif.m1_ack)) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack m0_ack=%0b m1_ack=%0b at cycle %0d", sif.m0_ack, sif.m1_ack, cyc);
      end else begin
        mon_e = sbq.pop_front();
        chk("ack_onehot", 32'(sif.m0_ack & sif.m1_ack), 32'h0);
        chk("ack_who", 32'(sif.m1_ack), 32'(mon_e.who));
        chk("ack_err", 32'(sif.ack_err), 32'(mon_e.err));
        chk("ack_cycle", 32'(cyc), 32'(mon_e.at));
        if (mon_e.chk_rd) chk("ack_rdata", 32'(sif.rdata), 32'(mon_e.rd));
      end
    end
  end

  task automatic req_set(input logic who, input logic [2:0] t, input logic [19:0] a, input logic [7:0] d);
    if (who) begin
      sif.m1_type = t; sif.m1_addr = a; sif.m1_wdata = d; sif.m1_req = 1'b1;
    end else begin
      sif.m0_type = t; sif.m0_addr = a; sif.m0_wdata = d; sif.m0_req = 1'b1;
    end
  endtask

  task automatic req_clr(input logic who);
    if (who) sif.m1_req = 1'b0;
    else     sif.m0_req = 1'b0;
  endtask

  task automatic wait_ack(input logic who, input int bound);
    int n = 0;
    while (!(who ? sif.m1_ack : sif.m0_ack) && (n < bound)) begin
      @(negedge clock);
      n++;
    end
    if (n >= bound) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout requester=%0d waited=%0d cycles", who, n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int aen_hi;
    reset_in = 1'b1;
    sif.m0_req = 1'b0; sif.m1_req = 1'b0;
    sif.m0_type = 3'b111; sif.m1_type = 3'b111;
    sif.m0_addr = 20'h0; sif.m1_addr = 20'h0;
    sif.m0_wdata = 8'h0; sif.m1_wdata = 8'h0;
    sif.bus_ready = 1'b1; sif.bus_rdata = 8'h00;
    repeat (2) @(negedge clock);
    reset_in = 1'b0;
    chk("rst_status", 32'(sif.processor_status), 32'h7);
    chk("rst_aen_n", 32'(sif.address_enable_n), 32'h1);
    chk("rst_acks", 32'({sif.m0_ack, sif.m1_ack}), 32'h0);
    chk("rst_ack_err", 32'(sif.ack_err), 32'h0);
    chk("rst_rdata", 32'(sif.rdata), 32'h0);
    chk("rst_bus_addr", 32'(sif.bus_addr), 32'h0);
    chk("rst_bus_wdata", 32'(sif.bus_wdata), 32'h0);
    chk("rst_oe", 32'(sif.bus_wdata_oe), 32'h0);
    chk("rst_owner", 32'(sif.owner), 32'h0);

    // m0 MEMR, no waits
    @(negedge clock); b = cyc;
    sif.bus_rdata = 8'hA5;
    expect_ack(1'b0, 1'b0, 1'b1, 8'hA5, b + 4);
    req_set(1'b0, 3'b101, 20'h12345, 8'h00);
    wait_ack(1'b0, 20); req_clr(1'b0);
    repeat (2) @(negedge clock);
    chk("memr_st_t1", 32'(st_tr[b+1]), 32'h5);
    chk("memr_st_t3", 32'(st_tr[b+3]), 32'h5);
    chk("memr_st_t4", 32'(st_tr[b+4]), 32'h7);
    chk("memr_aen_t1", 32'(aen_tr[b+1]), 32'h0);
    chk("memr_addr_t1", 32'(addr_tr[b+1]), 32'h12345);
    chk("memr_aen_idle", 32'(aen_tr[b+5]), 32'h1);

    // m0 IOW, bus not ready for three cycles starting at T3
    @(negedge clock); b = cyc;
    sif.bus_rdata = 8'h00;
    expect_ack(1'b0, 1'b0, 1'b1, 8'h00, b + 7);
    req_set(1'b0, 3'b010, 20'h00034, 8'h5A);
    repeat (3) @(negedge clock); sif.bus_ready = 1'b0;
    repeat (3) @(negedge clock); sif.bus_ready = 1'b1;
    wait_ack(1'b0, 20); req_clr(1'b0);
    repeat (2) @(negedge clock);
    chk("iow_oe_t1", 32'(oe_tr[b+1]), 32'h0);
    chk("iow_oe_t2", 32'(oe_tr[b+2]), 32'h1);
    chk("iow_oe_tw", 32'(oe_tr[b+5]), 32'h1);
    chk("iow_oe_t4", 32'(oe_tr[b+7]), 32'h1);
    chk("iow_oe_after", 32'(oe_tr[b+8]), 32'h0);
    chk("iow_st_tw", 32'(st_tr[b+6]), 32'h2);
    chk("iow_st_t4", 32'(st_tr[b+7]), 32'h7);
    chk("iow_wdata", 32'(wd_tr[b+2]), 32'h5A);

    // Simultaneous m0/m1 with owner=0: m1 first, two handovers
    @(negedge clock); b = cyc;
    sif.bus_rdata = 8'h11;
    expect_ack(1'b1, 1'b0, 1'b1, 8'h11, b + 5);
    expect_ack(1'b0, 1'b0, 1'b1, 8'h22, b + 11);
    fork
      begin req_set(1'b1, 3'b001, 20'h00200, 8'h00); wait_ack(1'b1, 30); req_clr(1'b1); end
      begin req_set(1'b0, 3'b101, 20'h00100, 8'h00); wait_ack(1'b0, 30); req_clr(1'b0); end
      begin repeat (5) @(negedge clock); sif.bus_rdata = 8'h22; end
    join
    repeat (2) @(negedge clock);
    chk("ho1_aen", 32'(aen_tr[b+1]), 32'h1);
    chk("ho1_owner", 32'(own_tr[b+1]), 32'h1);
    chk("ho1_st", 32'(st_tr[b+1]), 32'h7);
    chk("m1_st_t1", 32'(st_tr[b+2]), 32'h1);
    chk("m1_addr", 32'(addr_tr[b+2]), 32'h00200);
    chk("m1_aen_t4", 32'(aen_tr[b+5]), 32'h0);
    chk("mid_idle_aen", 32'(aen_tr[b+6]), 32'h1);
    chk("ho2_owner", 32'(own_tr[b+7]), 32'h0);
    chk("ho2_aen", 32'(aen_tr[b+7]), 32'h1);
    chk("m0_st_t1", 32'(st_tr[b+8]), 32'h5);
    chk("m0_addr", 32'(addr_tr[b+8]), 32'h00100);

    // m0 back-to-back fetches
    @(negedge clock); b = cyc;
    sif.bus_rdata = 8'h77;
    expect_ack(1'b0, 1'b0, 1'b1, 8'h77, b + 4);
    expect_ack(1'b0, 1'b0, 1'b1, 8'h77, b + 8);
    expect_ack(1'b0, 1'b0, 1'b1, 8'h77, b + 12);
    req_set(1'b0, 3'b100, 20'h00400, 8'h00);
    wait_ack(1'b0, 20); sif.m0_addr = 20'h00401; @(negedge clock);
    wait_ack(1'b0, 20); sif.m0_addr = 20'h00402; @(negedge clock);
    wait_ack(1'b0, 20); req_clr(1'b0);
    repeat (2) @(negedge clock);
    aen_hi = 0;
    for (int i = 1; i <= 12; i++) if (aen_tr[b+i] !== 1'b0) aen_hi++;
    chk("b2b_aen_high_cycles", 32'(aen_hi), 32'h0);
    chk("b2b_st_t4", 32'(st_tr[b+4]), 32'h7);
    chk("b2b_st_t1", 32'(st_tr[b+5]), 32'h4);
    chk("b2b_addr2", 32'(addr_tr[b+5]), 32'h00401);
    chk("b2b_addr3", 32'(addr_tr[b+9]), 32'h00402);
    chk("b2b_aen_idle", 32'(aen_tr[b+13]), 32'h1);

    // m1 illegal type 011
    @(negedge clock); b = cyc;
    expect_ack(1'b1, 1'b1, 1'b0, 8'h00, b + 1);
    req_set(1'b1, 3'b011, 20'h00ABC, 8'h00);
    wait_ack(1'b1, 10); req_clr(1'b1);
    repeat (2) @(negedge clock);
    chk("ill_st", 32'(st_tr[b+1]), 32'h7);
    chk("ill_st_next", 32'(st_tr[b+2]), 32'h7);
    chk("ill_aen", 32'(aen_tr[b+1]), 32'h1);
    chk("ill_owner", 32'(own_tr[b+2]), 32'h0);

    // Reset in the middle of TW: immediate passive bus, no ack
    @(negedge clock); b = cyc;
    sif.bus_rdata = 8'h99;
    req_set(1'b0, 3'b101, 20'h00500, 8'h00);
    repeat (3) @(negedge clock); sif.bus_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("tw_st", 32'(sif.processor_status), 32'h5);
    reset_in = 1'b1;
    #1;
    chk("async_rst_st", 32'(sif.processor_status), 32'h7);
    chk("async_rst_aen", 32'(sif.address_enable_n), 32'h1);
    chk("async_rst_oe", 32'(sif.bus_wdata_oe), 32'h0);
    req_clr(1'b0); sif.bus_ready = 1'b1;
    @(negedge clock); reset_in = 1'b0;
    @(negedge clock);
    chk("post_rst_st", 32'(sif.processor_status), 32'h7);
    chk("post_rst_aen", 32'(sif.address_enable_n), 32'h1);

    // Recovery: m0 MEMW after reset
    @(negedge clock); b = cyc;
    sif.bus_rdata = 8'hC3;
    expect_ack(1'b0, 1'b0, 1'b1, 8'hC3, b + 4);
    req_set(1'b0, 3'b110, 20'h00600, 8'hE7);
    wait_ack(1'b0, 20); req_clr(1'b0);
    repeat (2) @(negedge clock);
    chk("memw_st_t1", 32'(st_tr[b+1]), 32'h6);
    chk("memw_oe_t2", 32'(oe_tr[b+2]), 32'h1);
    chk("memw_wdata", 32'(wd_tr[b+2]), 32'hE7);

`ifdef KF8288_SEQ_TIMEOUT_EN
    // Timeout after 4 not-ready Tw cycles
    @(negedge clock); b = cyc;
    sif.bus_rdata = 8'h12;
    expect_ack(1'b0, 1'b1, 1'b1, 8'hFF, b + 8);
    req_set(1'b0, 3'b101, 20'h00700, 8'h00);
    repeat (3) @(negedge clock); sif.bus_ready = 1'b0;
    wait_ack(1'b0, 20); req_clr(1'b0); sif.bus_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk("to_st_tw4", 32'(st_tr[b+7]), 32'h5);
    chk("to_st_t4", 32'(st_tr[b+8]), 32'h7);
`endif

    repeat (3) @(negedge clock);
    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kf8288_bus_sequencer.md
Name: kf8288_bus_sequencer

Overview:
Sequences 8086-style bus cycles onto the KF8288 bus controller on behalf of two requesters: m0 (CPU core) and m1 (DMA/secondary master). It arbitrates between them, drives the 3-bit processor status S_n through T1/T2/T3/Tw/T4, and gates address_enable_n. It also presents address and write data, and returns read data with a one-cycle ack. It sits directly upstream of KF8288, feeding its processor_status and address_enable_n inputs.

Parameters:
WAIT_STATES, 0, minimum Tw cycles forced after T3 regardless of bus_ready (0..15)
ADDR_WIDTH, 20, address width
TIMEOUT_CYCLES, 255, max Tw cycles before forced completion (only with KF8288_SEQ_TIMEOUT_EN)

Ports:
clock  in  1  system clock, rising edge
reset_in  in  1  asynchronous, active-high reset
m0_req / m1_req  in  1  request; held with type/addr/wdata stable until matching ack
m0_type / m1_type  in  3  cycle type, S_n encoding: 000 INTA, 001 IOR, 010 IOW, 100 fetch, 101 MEMR, 110 MEMW; 011/111 illegal
m0_addr / m1_addr  in  ADDR_WIDTH  cycle address
m0_wdata / m1_wdata  in  8  write data
m0_ack / m1_ack  out  1  one-cycle completion pulse
ack_err  out  1  valid with ack: illegal type or timeout
rdata  out  8  read data, valid with ack
bus_ready  in  1  READY from bus, sampled in T3/Tw
bus_rdata  in  8  bus read data
processor_status  out  3  S_n to KF8288
address_enable_n  out  1  AEN_n to KF8288
bus_addr  out  ADDR_WIDTH  latched cycle address
bus_wdata  out  8  write data
bus_wdata_oe  out  1  write data drive enable (T2..T4 of write cycles)
owner  out  1  current bus owner (0 = m0, 1 = m1)

Behaviour:
- Reset values: processor_status=111, address_enable_n=1, acks=0, ack_err=0, rdata=0, bus_addr=0, bus_wdata=0, bus_wdata_oe=0, owner=0, state=IDLE. Assertion mid-cycle aborts immediately, with no ack issued.
- States: IDLE, HANDOVER, T1, T2, T3, TW, T4.
- IDLE: status 111. Arbitration: m1 has fixed priority over m0. The winner is latched (addr, type, wdata) and the FSM goes to T1. If the winner differs from owner, the FSM goes to HANDOVER first.
- HANDOVER: one cycle with address_enable_n=1, owner updated, then T1.
- T1: status=type, bus_addr valid, address_enable_n=0.
- T2: status held; bus_wdata_oe=1 for IOW/MEMW.
- T3: status held. Go to T4 only if bus_ready=1 and the forced-wait counter has reached WAIT_STATES; otherwise go to TW.
- TW: same exit test as T3; stay in TW until it passes.
- T4: status=111. Ack for the owner pulses. rdata was captured from bus_rdata on the sampling edge in T3/TW. Go to IDLE, or back-to-back to T1 if a same-owner request is pending, with no idle cycle.
- Latency: zero waits, same owner, ready high: req seen in IDLE at cycle 0 → T1@1, T2@2, T3@3, T4@4 with ack. Owner change adds 1 cycle.
- Illegal type (011/111): no bus cycle, status stays 111, ack plus ack_err the cycle after acceptance.
- No preemption: a request arriving mid-cycle waits for T4. address_enable_n stays 0 between back-to-back cycles of the same owner; otherwise 1 in IDLE.
- A requester dropping req before its ack is a protocol violation. The cycle still completes and its ack is still issued.

Optional Feature:
KF8288_SEQ_TIMEOUT_EN:
- When defined: a counter runs while in TW. After TIMEOUT_CYCLES consecutive Tw cycles with bus_ready=0, the FSM forces T4, acks with ack_err=1, and sets rdata=FF.
- When not defined: TW waits indefinitely and ack_err flags illegal types only.

Decomposition:
- Package kf8288_seq_pkg: bus_status_t enum (the 8 S_n codes, PASSIVE=111), seq_state_t enum, and constant STATUS_PASSIVE.
- Sub-module kf8288_seq_arbiter: fixed-priority select, owner register, handover-required flag.
- The FSM, wait counter and datapath latches live in the top module.

Test Plan:
- m0 MEMR addr 0x12345, WAIT_STATES=0, ready=1 → S_n 101 for cycles 1-3, 111 at 4; m0_ack at cycle 4 with rdata = bus_rdata sampled in T3 (0xA5).
- m0 IOW wdata 0x5A, ready held low 3 cycles in T3 → 3 Tw cycles, bus_wdata_oe=1 from T2 through T4, ack at cycle 7.
- m0 and m1 requesting simultaneously from IDLE with owner=0 → HANDOVER (AEN_n=1, owner=1), m1 cycle first, m0 starts after m1 T4 with a further HANDOVER.
- m0 back-to-back fetches (type 100) → T4 followed directly by T1, AEN_n continuously 0, one ack every 4 cycles.
- m1 type 011 → no status change from 111, m1_ack plus ack_err one cycle after acceptance.
- reset_in pulsed during TW → S_n=111 and AEN_n=1 asynchronously, no ack; TIMEOUT_EN build with TIMEOUT_CYCLES=4 and ready=0 → ack_err after 4 Tw, rdata=FF.
